// File: rtl/can_interframe_tracker_if.sv
// Bus-side bundle for the CAN interframe tracker.
// Carries the sampler inputs plus the phase/permission outputs.
interface can_interframe_tracker_if #(
  parameter int CNT_W = 5
);
  logic             dIn;
  logic             samplePulse;
  logic             rateSelector;
  logic             errorPassive;
  logic             bitValid;
  logic             bitValue;
  logic [CNT_W-1:0] recCount;
  logic             intermission;
  logic             overloadDetect;
  logic             txReady;
  logic [1:0]       phase;

  modport master (
    output dIn,
    output samplePulse,
    output rateSelector,
    output errorPassive,
    input  bitValid,
    input  bitValue,
    input  recCount,
    input  intermission,
    input  overloadDetect,
    input  txReady,
    input  phase
  );

  modport slave (
    input  dIn,
    input  samplePulse,
    input  rateSelector,
    input  errorPassive,
    output bitValid,
    output bitValue,
    output recCount,
    output intermission,
    output overloadDetect,
    output txReady,
    output phase
  );
endinterface

// File: rtl/can_interframe_tracker.sv
// CAN interframe tracker: bit voter plus FRAME/INTER/SUSPEND/IDLE FSM.
// Define CAN_IFT_MAJORITY_EN for a 2-of-3 vote at rateSelector = 1.
module can_interframe_tracker #(
  parameter int PRE_BITS          = 8,
  parameter int INTERMISSION_BITS = 3,
  parameter int SUSPEND_BITS      = 8,
  parameter int CNT_W             = 5
) (
  input logic                     clk,
  input logic                     reset,
  can_interframe_tracker_if.slave bus
);

  localparam logic [1:0] ST_FRAME   = 2'd0;
  localparam logic [1:0] ST_INTER   = 2'd1;
  localparam logic [1:0] ST_SUSPEND = 2'd2;
  localparam logic [1:0] ST_IDLE    = 2'd3;

  localparam logic [CNT_W-1:0] PRE_C = CNT_W'(PRE_BITS);
  localparam logic [CNT_W-1:0] INT_C = CNT_W'(INTERMISSION_BITS);
  localparam logic [CNT_W-1:0] SUS_C = CNT_W'(SUSPEND_BITS);
  localparam logic [CNT_W-1:0] SAT_C = {CNT_W{1'b1}};
  localparam bit               SUS_EN = (SUSPEND_BITS > 0);

  logic [1:0]       idx;
  logic             rate_q;
  logic [1:0]       smp;
  logic             rate_now;
  logic             last;
  logic             voted;
  logic             bit_valid;
  logic             bit_value;
  logic [1:0]       state;
  logic [CNT_W-1:0] rec;
  logic [CNT_W-1:0] rec_inc;
  logic             saw_dom;
  logic             ovl;

  // Rate is latched on the first sample so a mid-bit change is ignored
  assign rate_now = (idx == 2'd0) ? bus.rateSelector : rate_q;
  assign last     = bus.samplePulse &&
                    (!rate_now || idx == 2'd2);

`ifdef CAN_IFT_MAJORITY_EN
  assign voted = rate_now ?
                 ((smp[0] & smp[1]) |
                  (smp[0] & bus.dIn) |
                  (smp[1] & bus.dIn)) :
                 bus.dIn;
`else
  assign voted = bus.dIn;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= 2'd0;
      rate_q    <= 1'b0;
      smp       <= 2'b00;
      bit_valid <= 1'b0;
      bit_value <= 1'b0;
    end else begin
      bit_valid <= last;
      if (bus.samplePulse) begin
        if (idx == 2'd0) rate_q <= bus.rateSelector;
        if (last) begin
          idx       <= 2'd0;
          bit_value <= voted;
        end else begin
          smp[idx[0]] <= bus.dIn;
          idx         <= idx + 2'd1;
        end
      end
    end
  end

  assign rec_inc = rec + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_FRAME;
      rec     <= '0;
      saw_dom <= 1'b0;
      ovl     <= 1'b0;
    end else begin
      ovl <= 1'b0;
      if (bit_valid) begin
        unique case (state)
          ST_FRAME: begin
            if (!bit_value) begin
              rec     <= '0;
              saw_dom <= 1'b1;
            end else if (rec_inc == PRE_C) begin
              state <= ST_INTER;
              rec   <= '0;
            end else begin
              rec <= rec_inc;
            end
          end
          ST_INTER: begin
            if (!bit_value) begin
              // Dominant early in intermission is overload, later is SOF
              ovl   <= (rec < CNT_W'(2));
              state <= ST_FRAME;
              rec   <= '0;
            end else if (rec_inc == INT_C) begin
              rec <= '0;
              if (bus.errorPassive && saw_dom && SUS_EN)
                state <= ST_SUSPEND;
              else
                state <= ST_IDLE;
            end else begin
              rec <= rec_inc;
            end
          end
          ST_SUSPEND: begin
            if (!bit_value) begin
              state <= ST_FRAME;
              rec   <= '0;
            end else if (rec_inc == SUS_C) begin
              state <= ST_IDLE;
              rec   <= '0;
            end else begin
              rec <= rec_inc;
            end
          end
          ST_IDLE: begin
            if (!bit_value) begin
              state <= ST_FRAME;
              rec   <= '0;
            end else if (rec != SAT_C) begin
              rec <= rec_inc;
            end
          end
          default: begin
            state <= ST_FRAME;
            rec   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.bitValid       = bit_valid;
  assign bus.bitValue       = bit_value;
  assign bus.recCount       = rec;
  assign bus.intermission   = (state == ST_INTER);
  assign bus.overloadDetect = ovl;
  assign bus.txReady        = (state == ST_IDLE);
  assign bus.phase          = state;

endmodule

// File: doc/can_interframe_tracker.md
Name: can_interframe_tracker

Overview:
- Parametrised successor to the CAN interframe detector in ch_unit.
- Votes the oversampled bus bit and tracks consecutive recessive bits through the ACK delimiter and EOF, then intermission and an optional error-passive suspend.
- Flags overload conditions and drives a transmit-permission signal to the channel controller.
- Sits between the bit-timing unit (samplePulse source) and the frame TX/RX controllers.

Parameters:
- PRE_BITS, 8: recessive bits before intermission (ACK delimiter + 7 EOF); range 1..(2^CNT_W - 1).
- INTERMISSION_BITS, 3: intermission length in bits; must be ≥3.
- SUSPEND_BITS, 8: suspend-transmission length for error-passive nodes; 0 disables suspend.
- CNT_W, 5: width of the recessive counter and of recCount.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dIn  in  1  synchronised RX bus level (1 = recessive)
- samplePulse  in  1  one-cycle strobe per sample point
- rateSelector  in  1  1 = 3 samples per bit, 0 = 1 sample per bit; sampled at the first sample of each bit
- errorPassive  in  1  node is error-passive; sampled on the bit that ends intermission
- bitValid  out  1  one-cycle strobe: voted bit available
- bitValue  out  1  voted bit, held until the next bitValid
- recCount  out  CNT_W  count of recessive bits within the current phase
- intermission  out  1  high during ST_INTER
- overloadDetect  out  1  one-cycle pulse: dominant bit in intermission bit 0 or 1
- txReady  out  1  high in ST_IDLE; replaces interframePeriod
- phase  out  2  current phase: 0 FRAME, 1 INTER, 2 SUSPEND, 3 IDLE

Behaviour:
- Reset values: all outputs 0; phase = FRAME; sample index 0; sawDominant = 0.
- Sampler:
  - The sample index advances on each samplePulse.
  - The bit completes on the 3rd pulse (rateSelector = 1) or the 1st pulse (rateSelector = 0).
  - bitValid rises the cycle after the completing pulse.
  - A samplePulse coincident with bitValid counts as sample 1 of the next bit; no pulse is dropped.
- All FSM updates occur only on bitValid cycles; otherwise state and counters hold.
- FRAME:
  - Dominant bit → recCount = 0, set sawDominant.
  - Recessive bit → recCount+1. When recCount+1 == PRE_BITS → INTER, recCount = 0.
- INTER:
  - Recessive bit → recCount+1. When recCount+1 == INTERMISSION_BITS:
    - → SUSPEND if errorPassive && sawDominant && SUSPEND_BITS > 0;
    - → IDLE otherwise.
    - recCount = 0 in both cases.
  - Dominant bit at recCount 0 or 1 → overloadDetect pulse (same cycle as the FRAME transition is registered), → FRAME, recCount = 0.
  - Dominant bit at recCount ≥ 2 → treated as SOF, → FRAME, no overload.
- SUSPEND:
  - Recessive bit → recCount+1; at SUSPEND_BITS → IDLE.
  - Dominant bit → FRAME (SOF from another node), recCount = 0.
- IDLE:
  - Recessive bit → stay; recCount saturates at 2^CNT_W - 1.
  - Dominant bit → FRAME, recCount = 0.
- Bus integration: after reset, PRE_BITS + INTERMISSION_BITS recessive bits reach IDLE with no suspend, because sawDominant = 0.
- Output timing:
  - intermission, txReady and phase are registered from the state.
  - txReady drops the cycle after the dominant bitValid.
- Reset asserted mid-bit or mid-phase: the partial vote is discarded and all state returns to reset values on the next edge.
- Counters never wrap; compare-equal transitions occur before overflow given the parameter ranges.

Optional Feature:
- Macro: CAN_IFT_MAJORITY_EN
- Defined: with rateSelector = 1, bitValue = majority of the 3 samples.
- Undefined: bitValue = the last (3rd) sample only, matching the legacy detector; rateSelector = 0 behaviour is identical in both builds.

Test Plan:
- Reset, rateSelector = 1, 11 recessive bits (33 pulses) → txReady rises after the 11th bitValid; phase = 3; no suspend; overloadDetect never pulses.
- Dominant bit, 8 recessive, then dominant on intermission bit 1 → overloadDetect pulses once; phase returns to 0; txReady stays 0.
- Same sequence, dominant on intermission bit 2 → no overload; phase = 0 (SOF).
- errorPassive = 1 after a dominant bit, then 19 recessive bits → SUSPEND entered after bit 11; txReady rises only after bit 19.
- Samples 1,0,1 per bit with macro defined → bitValue = 1; undefined with samples 1,1,0 → bitValue = 0.
- Reset asserted for one cycle while recCount = 5 in FRAME → next cycle phase = 0, recCount = 0, all outputs 0; samplePulse coincident with bitValid → the next bit still completes after 3 pulses.
